imem_loader: RTL

- Writer side of the instruction-memory interface. The controller only reads instruction memory; this block fills it.
- Assembles 16-bit instruction words from 4-bit nibbles supplied on the board switch/nibble interface.
- Writes each word sequentially into the instruction memory write port.
- Holds the CPU in reset (cpu_hold) while a load is in progress, and releases it when the load ends.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_nibble_assembler.sv | 48 ++++
 rtl/imem_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int NIBBLES_PER_WORD = 4;
  localparam int WORD_W           = 16;
  localparam int NIB_W            = 4;

  typedef logic [1:0] loader_state_t;

  localparam loader_state_t ST_IDLE    = 2'd0;
  localparam loader_state_t ST_COLLECT = 2'd1;
  localparam loader_state_t ST_WRITE   = 2'd2;
  localparam loader_state_t ST_DONE    = 2'd3;

  // Shift a partial word up so its n collected nibbles sit at the top, zero fill below.
  function automatic logic [WORD_W-1:0] left_align(input logic [WORD_W-1:0] w,
                                                   input logic [1:0] n);
    logic [WORD_W-1:0] r;
    case (n)
      2'd1:    r = w << 12;
      2'd2:    r = w << 8;
      2'd3:    r = w << 4;
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_nibble_assembler.sv
// Builds 16-bit words from MS-first nibbles; full_o flags the 4th nibble being shifted in,
// partial_o flags a non-empty word after this cycle's shift. Registered, no backpressure.
module nibble_assembler
  import imem_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              shift_i,
  input  logic [NIB_W-1:0]  nibble_i,
  input  logic              clear_i,
  input  logic              pad_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o,
  output logic              partial_o
);

  logic [WORD_W-1:0] word_q, word_d, word_sh;
  logic [1:0]        cnt_q, cnt_d, cnt_sh;

  always_comb begin
    word_sh = shift_i ? {word_q[WORD_W-NIB_W-1:0], nibble_i} : word_q;
    cnt_sh  = cnt_q + {1'b0, shift_i};
    word_d  = word_sh;
    cnt_d   = cnt_sh;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (pad_i) begin
      // A nibble arriving alongside pad is already folded into word_sh/cnt_sh.
      word_d = left_align(word_sh, cnt_sh);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o    = word_q;
  assign full_o    = shift_i && (cnt_q == 2'd3);
  assign partial_o = (cnt_sh != 2'd0);

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a nibble stream, holding the CPU in reset while loading; im_wren
// fires the cycle after a word's 4th nibble, nibble_ready drops that cycle. LOADER_CHECKSUM_EN adds a word checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              nibble_valid,
  input  logic [NIB_W-1:0]  nibble,
  output logic              nibble_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_data,
  output logic              im_wren,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [WORD_W-1:0] checksum
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              ovf_q, ovf_d;
  logic              pend_q, pend_d;   // finish already consumed: go to DONE after this write
  logic              cap_q, cap_d;     // finish seen during WRITE, applied back in COLLECT
  logic              accept, load_start, fin_eff, asm_clear, asm_pad;
  logic              asm_full, asm_partial;
  logic [WORD_W-1:0] asm_word;

  assign accept  = nibble_valid && (state_q == ST_COLLECT);
  assign fin_eff = finish || cap_q;

  nibble_assembler u_asm (
    .clock     (clock),
    .reset     (reset),
    .shift_i   (accept),
    .nibble_i  (nibble),
    .clear_i   (asm_clear),
    .pad_i     (asm_pad),
    .word_o    (asm_word),
    .full_o    (asm_full),
    .partial_o (asm_partial)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wc_d       = wc_q;
    ovf_d      = ovf_q;
    pend_d     = pend_q;
    cap_d      = 1'b0;
    asm_clear  = 1'b0;
    asm_pad    = 1'b0;
    load_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_start = 1'b1;
          state_d    = ST_COLLECT;
          addr_d     = '0;
          wc_d       = '0;
          ovf_d      = 1'b0;
          pend_d     = 1'b0;
          asm_clear  = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (asm_full) begin
          if (wc_q == DEPTH_C) begin
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
            pend_d  = fin_eff;
          end
        end else if (fin_eff) begin
          if (!asm_partial) begin
            state_d = ST_DONE;
          end else if (wc_q == DEPTH_C) begin
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            asm_pad = 1'b1;
            pend_d  = 1'b1;
            state_d = ST_WRITE;
          end
        end
      end
      default: begin
        addr_d    = addr_q + ADDR_W'(1);
        wc_d      = wc_q + (ADDR_W+1)'(1);
        asm_clear = 1'b1;
        pend_d    = 1'b0;
        if (pend_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COLLECT;
          cap_d   = finish;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      cap_q   <= cap_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] cks_q;

  always_ff @(posedge clock) begin
    if (reset || load_start) begin
      cks_q <= '0;
    end else if (state_q == ST_WRITE) begin
      cks_q <= cks_q + asm_word;
    end
  end

  assign checksum = cks_q;
`else
  logic unused_load_start;
  assign unused_load_start = load_start;
  assign checksum          = '0;
`endif

  assign nibble_ready = (state_q == ST_COLLECT);
  assign im_wren      = (state_q == ST_WRITE);
  assign im_addr      = addr_q;
  assign im_data      = asm_word;
  assign busy         = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign cpu_hold     = busy;
  assign done         = (state_q == ST_DONE);
  assign overflow     = ovf_q;
  assign word_count   = wc_q;

endmodule
